// File: rtl/iu_pkg.sv
// Shared definitions for the warp issue unit: default sizes and small
// index helpers used by the arbiters and the pointer registers.
package iu_pkg;

  localparam int NUM_WARPS_DEF    = 8;
  localparam int LOGNUM_WARPS_DEF = $clog2(NUM_WARPS_DEF);

  // Position of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic int onehot2idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Round-robin successor: ptr+1, wrapping from n-1 back to 0.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found when
// scanning upward from ptr (inclusive), wrapping at N-1 -> 0.
module rr_arbiter
  import iu_pkg::*;
#(
  parameter int N = NUM_WARPS_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic found;

  // Scan requesters starting at ptr and keep only the first hit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        gnt[(int'(ptr) + i) % N] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

  assign any = found;
  assign idx = W'(onehot2idx(32'(gnt)));

endmodule

// File: rtl/issue_unit.sv
// Per-SM warp issue scheduler. Each cycle it grants at most one warp to
// retire (exit) and at most one warp to issue, both round-robin, honouring
// Operand Collector backpressure and blocking warps with an unresolved branch.
// Optional build macro: ISSUE_GTO_EN selects greedy-then-oldest issue policy
// (re-grant the last issued warp while it stays eligible).
module issue_unit
  import iu_pkg::*;
#(
  parameter int NUM_WARPS    = NUM_WARPS_DEF,
  parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WARPS-1:0]    req_IB_IU,
  input  logic [NUM_WARPS-1:0]    branch_IB_IU,
  input  logic [NUM_WARPS-1:0]    exit_req_IB_IU,
  input  logic                    OC_full_OC_IU,
  input  logic                    BrResolved_Valid_SIMT_IU,
  input  logic [LOGNUM_WARPS-1:0] BrResolved_WarpID_SIMT_IU,
  output logic [NUM_WARPS-1:0]    grt_IU_IB,
  output logic [NUM_WARPS-1:0]    exit_grt_IU_IB,
  output logic [NUM_WARPS-1:0]    br_pending_IU
);

  logic [LOGNUM_WARPS-1:0] issue_ptr;
  logic [LOGNUM_WARPS-1:0] exit_ptr;
`ifdef ISSUE_GTO_EN
  logic [LOGNUM_WARPS-1:0] last_warp;
`endif

  logic [NUM_WARPS-1:0]    exit_gnt;
  logic [LOGNUM_WARPS-1:0] exit_idx;
  logic                    exit_any;

  logic [NUM_WARPS-1:0]    issue_req;
  logic [NUM_WARPS-1:0]    rr_gnt;
  logic [LOGNUM_WARPS-1:0] rr_idx;
  logic                    rr_any;

  logic [NUM_WARPS-1:0]    issue_gnt;
  logic [LOGNUM_WARPS-1:0] issue_idx;
  logic                    issue_any;

  logic [NUM_WARPS-1:0]    br_next;

  rr_arbiter #(.N(NUM_WARPS), .W(LOGNUM_WARPS)) u_exit_arb (
    .req (exit_req_IB_IU),
    .ptr (exit_ptr),
    .gnt (exit_gnt),
    .idx (exit_idx),
    .any (exit_any)
  );

  // No grants leave the unit while reset is held.
  assign exit_grt_IU_IB = rst ? exit_gnt : '0;

  // A warp retiring this cycle, or waiting on a branch, cannot issue; a full
  // Operand Collector blocks issue entirely.
  assign issue_req = OC_full_OC_IU ? '0
                                   : (req_IB_IU & ~br_pending_IU & ~exit_grt_IU_IB);

  rr_arbiter #(.N(NUM_WARPS), .W(LOGNUM_WARPS)) u_issue_arb (
    .req (issue_req),
    .ptr (issue_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Final issue choice: round-robin, optionally overridden by the greedy warp.
  always_comb begin
    issue_gnt = rr_gnt;
    issue_idx = rr_idx;
    issue_any = rr_any;
`ifdef ISSUE_GTO_EN
    if (issue_req[last_warp]) begin
      issue_gnt            = '0;
      issue_gnt[last_warp] = 1'b1;
      issue_idx            = last_warp;
      issue_any            = 1'b1;
    end
`endif
  end

  assign grt_IU_IB = rst ? issue_gnt : '0;

  // Next branch-block mask: resolve and exit clear, a new branch grant sets
  // (applied last so a same-warp set/clear collision keeps the block).
  always_comb begin
    br_next = br_pending_IU;
    if (BrResolved_Valid_SIMT_IU) br_next[BrResolved_WarpID_SIMT_IU] = 1'b0;
    br_next = br_next & ~exit_grt_IU_IB;
    br_next = br_next | (grt_IU_IB & branch_IB_IU);
  end

  // Pointer and mask registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      issue_ptr     <= '0;
      exit_ptr      <= '0;
      br_pending_IU <= '0;
`ifdef ISSUE_GTO_EN
      last_warp     <= '0;
`endif
    end else begin
      if (exit_any) exit_ptr <= LOGNUM_WARPS'(rr_next(int'(exit_idx), NUM_WARPS));
      if (issue_any) begin
        issue_ptr <= LOGNUM_WARPS'(rr_next(int'(issue_idx), NUM_WARPS));
`ifdef ISSUE_GTO_EN
        last_warp <= issue_idx;
`endif
      end
      br_pending_IU <= br_next;
    end
  end

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios plus randomized
// traffic, all compared against a behavioural scheduler model.
module tb_issue_unit;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] branch = '0;
  logic [N-1:0] exit_req = '0;
  logic         oc_full = 1'b0;
  logic         br_valid = 1'b0;
  logic [2:0]   br_id = '0;
  logic [N-1:0] grt;
  logic [N-1:0] exit_grt;
  logic [N-1:0] br_pending;

  int checks = 0;
  int errors = 0;

  // Model state: pointers, last issued warp, pending-branch flags.
  int m_iptr = 0;
  int m_eptr = 0;
  int m_last = 0;
  bit m_pend[N];

  issue_unit dut (
    .clk                       (clk),
    .rst                       (rst),
    .req_IB_IU                 (req),
    .branch_IB_IU              (branch),
    .exit_req_IB_IU            (exit_req),
    .OC_full_OC_IU             (oc_full),
    .BrResolved_Valid_SIMT_IU  (br_valid),
    .BrResolved_WarpID_SIMT_IU (br_id),
    .grt_IU_IB                 (grt),
    .exit_grt_IU_IB            (exit_grt),
    .br_pending_IU             (br_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One cycle: drive inputs after the falling edge, compare outputs against
  // the model before the rising edge, then advance the model.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] br,
                      input logic [N-1:0] ex, input logic oc, input logic rv,
                      input logic [2:0] rid);
    int ew, iw;
    logic [N-1:0] exp_e, exp_g;
    @(negedge clk);
    rst = r; req = rq; branch = br; exit_req = ex;
    oc_full = oc; br_valid = rv; br_id = rid;
    #1;
    exp_e = '0; exp_g = '0; ew = -1; iw = -1;
    if (r) begin
      for (int k = 0; k < N; k++) begin
        if (ex[(m_eptr + k) % N]) begin ew = (m_eptr + k) % N; break; end
      end
      if (ew >= 0) exp_e[ew] = 1'b1;
      if (!oc) begin
`ifdef ISSUE_GTO_EN
        if (rq[m_last] && !m_pend[m_last] && m_last != ew) iw = m_last;
`endif
        if (iw < 0) begin
          for (int k = 0; k < N; k++) begin
            int w;
            w = (m_iptr + k) % N;
            if (rq[w] && !m_pend[w] && w != ew) begin iw = w; break; end
          end
        end
      end
      if (iw >= 0) exp_g[iw] = 1'b1;
    end
    check("br_pending", br_pending, pend_vec());
    check("exit_grant", exit_grt, exp_e);
    check("issue_grant", grt, exp_g);
    if (!r) begin
      m_iptr = 0; m_eptr = 0; m_last = 0;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    end else begin
      if (rv) m_pend[rid] = 1'b0;
      if (ew >= 0) begin m_eptr = (ew + 1) % N; m_pend[ew] = 1'b0; end
      if (iw >= 0) begin
        m_iptr = (iw + 1) % N;
        m_last = iw;
        if (br[iw]) m_pend[iw] = 1'b1;
      end
    end
  endtask

  task automatic idle_reset();
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;

    // Reset: grants held low even with every request raised.
    step(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 3'd0);
    check("reset_grt", grt, 8'h00);
    check("reset_exit", exit_grt, 8'h00);
    idle_reset();

`ifndef ISSUE_GTO_EN
    // Round-robin fairness across all warps, then wrap.
    for (int i = 0; i < 9; i++) begin
      logic [N-1:0] e;
      e = '0; e[i % N] = 1'b1;
      step(1'b1, 8'hFF, '0, '0, 1'b0, 1'b0, 3'd0);
      check("rr_seq", grt, e);
    end
`else
    // Greedy: warp 1 keeps the grant, then warp 2 once warp 1 drops out.
    step(1'b1, 8'h06, '0, '0, 1'b0, 1'b0, 3'd0);
    check("gto_first", grt, 8'h02);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h06, '0, '0, 1'b0, 1'b0, 3'd0);
      check("gto_stick", grt, 8'h02);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h04, '0, '0, 1'b0, 1'b0, 3'd0);
      check("gto_move", grt, 8'h04);
    end
`endif

    // Backpressure holds grants and pointer.
    idle_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h0C, '0, '0, 1'b1, 1'b0, 3'd0);
      check("oc_full_grt", grt, 8'h00);
    end
    step(1'b1, 8'h0C, '0, '0, 1'b0, 1'b0, 3'd0);
    check("oc_release", grt, 8'h04);
`ifndef ISSUE_GTO_EN
    step(1'b1, 8'h0C, '0, '0, 1'b0, 1'b0, 3'd0);
    check("oc_next", grt, 8'h08);
`endif

    // Branch block until SIMT resolves warp 1.
    idle_reset();
    step(1'b1, 8'h02, 8'h02, '0, 1'b0, 1'b0, 3'd0);
    check("br_issue", grt, 8'h02);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h02, 8'h02, '0, 1'b0, 1'b0, 3'd0);
      check("br_blocked", grt, 8'h00);
      check("br_mask", br_pending, 8'h02);
    end
    step(1'b1, 8'h02, 8'h00, '0, 1'b0, 1'b1, 3'd1);
    check("br_resolve_cycle", grt, 8'h00);
    step(1'b1, 8'h02, 8'h00, '0, 1'b0, 1'b0, 3'd0);
    check("br_reissue", grt, 8'h02);
    check("br_cleared", br_pending, 8'h00);

    // Exit/issue collision on the same warp.
    step(1'b1, 8'h10, '0, 8'h10, 1'b0, 1'b0, 3'd0);
    check("coll_exit", exit_grt, 8'h10);
    check("coll_issue", grt, 8'h00);
    step(1'b1, 8'h30, '0, 8'h10, 1'b0, 1'b0, 3'd0);
    check("coll2_exit", exit_grt, 8'h10);
    check("coll2_issue", grt, 8'h20);

    // Reset mid-run discards mask and pointers.
    idle_reset();
    step(1'b1, 8'h01, 8'h01, '0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 8'h04, 8'h04, '0, 1'b0, 1'b0, 3'd0);
    step(1'b1, '0, '0, '0, 1'b0, 1'b0, 3'd0);
    check("mid_mask", br_pending, 8'h05);
    step(1'b0, 8'hFF, '0, '0, 1'b0, 1'b0, 3'd0);
    check("mid_rst_grt", grt, 8'h00);
    step(1'b1, 8'hFF, '0, '0, 1'b0, 1'b0, 3'd0);
    check("mid_after_grt", grt, 8'h01);
    check("mid_after_mask", br_pending, 8'h00);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic r, oc, rv;
      logic [N-1:0] rq, br, ex;
      logic [2:0] rid;
      r   = ($urandom_range(0, 49) != 0);
      rq  = N'($urandom);
      br  = N'($urandom) & N'($urandom);
      ex  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      oc  = ($urandom_range(0, 4) == 0);
      rv  = ($urandom_range(0, 2) == 0);
      rid = 3'($urandom);
      step(r, rq, br, ex, oc, rv, rid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Per-SM warp issue scheduler between the per-warp instruction buffers and the Operand Collector / RAU exit path.
- Each cycle it picks at most one warp to issue (grt_IU_IB) and at most one warp to retire (exit_grt_IU_IB).
- Selection is round-robin over requesting warps.
- Respects OC backpressure and blocks a warp that has issued a branch until SIMT resolves it.

Parameters:
- NUM_WARPS, 8, number of warps / requesters
- LOGNUM_WARPS, $clog2(NUM_WARPS), warp ID width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- req_IB_IU  in  NUM_WARPS  per-warp issue request (head instr ready, Scb-cleared)
- branch_IB_IU  in  NUM_WARPS  per-warp: head instr is BEQ/BLT
- exit_req_IB_IU  in  NUM_WARPS  per-warp exit request
- OC_full_OC_IU  in  1  Operand Collector cannot accept this cycle
- BrResolved_Valid_SIMT_IU  in  1  branch outcome resolved
- BrResolved_WarpID_SIMT_IU  in  LOGNUM_WARPS  warp of resolved branch
- grt_IU_IB  out  NUM_WARPS  one-hot issue grant (combinational, same cycle)
- exit_grt_IU_IB  out  NUM_WARPS  one-hot exit grant (combinational, same cycle)
- br_pending_IU  out  NUM_WARPS  registered per-warp branch-block mask (debug/SIMT)

Behaviour:
- Reset: while rst==0 at a clk edge, issue_ptr=0, exit_ptr=0, br_pending=0, last_warp=0. Grants are forced 0 in any cycle where rst==0.
- Exit arbitration:
  - Round-robin over exit_req_IB_IU, starting at exit_ptr inclusive, wrapping at NUM_WARPS-1 -> 0.
  - Not gated by OC_full or br_pending.
  - On a grant to warp w, exit_ptr <= (w+1) mod NUM_WARPS next edge. With no grant, the pointer holds.
- Issue eligibility:
  - elig = req_IB_IU & ~br_pending & ~exit_grt_IU_IB.
  - A warp exiting this cycle never also issues.
- Issue arbitration:
  - If OC_full_OC_IU==1, grt_IU_IB=0 and state holds.
  - Otherwise round-robin over elig starting at issue_ptr inclusive.
  - On a grant to w: issue_ptr <= (w+1) mod NUM_WARPS; last_warp <= w.
- At most one bit set in each grant vector. Both vectors are zero when no request exists.
- Branch blocking:
  - If grt_IU_IB[w] && branch_IB_IU[w], then br_pending[w] <= 1 at the next edge.
  - On BrResolved_Valid_SIMT_IU, br_pending[BrResolved_WarpID_SIMT_IU] <= 0.
  - Resolve for a non-pending warp: no effect.
  - Resolve and a new branch grant for different warps in the same cycle: both take effect.
  - Same-warp collision cannot occur because pending warps are ineligible. If it does occur, set wins.
- Exit grant to w also clears br_pending[w].
- Latency: grant 0 cycles after request; pointer and mask updates visible the next cycle.
- Grant is a single-cycle pulse. A warp still requesting on the next cycle is re-arbitrated normally.
- Reset mid-operation discards pending masks and pointers; no grant is issued in the reset cycle.

Optional Feature:
- ISSUE_GTO_EN defined: greedy-then-oldest issue policy.
  - If elig[last_warp] is set, grant last_warp again.
  - Otherwise fall back to round-robin from issue_ptr.
  - Exit arbitration is unchanged.
- ISSUE_GTO_EN undefined: pure round-robin as above; last_warp register may be optimized away.

Decomposition:
- Package iu_pkg:
  - NUM_WARPS / LOGNUM_WARPS defaults.
  - Function onehot2idx.
  - Function rr_next(ptr), the wrap increment.
- Sub-module rr_arbiter: parameterized N-wide combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: one-hot gnt, idx, any.
  - Instantiated twice, for issue and exit.
- issue_unit owns all registers.

Test Plan:
- RR fairness: req=8'hFF for 8 cycles, OC_full=0 -> grt sequence 01,02,04,...,80, then wraps to 01.
- Backpressure: req=8'h0C, issue_ptr=0, OC_full=1 for 3 cycles -> grt=0 and ptr held; deassert OC_full -> grt=8'h04, then 8'h08.
- Branch block: req=8'h02 with branch_IB_IU=8'h02 -> grt=02; next cycles grt=0 with br_pending=02 until BrResolved_Valid=1, WarpID=1; following cycle grt=02 again.
- Exit/issue collision: req=8'h10, exit_req=8'h10 -> exit_grt=10, grt=00; with req=8'h30 -> exit_grt=10, grt=20.
- Reset mid-run: br_pending=8'h05, issue_ptr=3, assert rst=0 one edge with req=8'hFF -> grants 0 that cycle; after release grt=01 and br_pending=0.
- GTO (ISSUE_GTO_EN): req=8'h06 steady -> grt=02 every cycle; drop req[1] -> grt=04 and sticks there.
